// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard to UART bridge: prefix FSM states,
// scancode and ASCII constants, and the Set-2 to ASCII lookup.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // Returns {valid, ascii}; valid=0 means the code produces no output.
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] sc,
                                             input logic shift,
                                             input logic caps);
    logic [7:0] lower;
    logic [7:0] plain;
    logic [7:0] shifted;
    logic [8:0] result;
    lower   = 8'h00;
    plain   = 8'h00;
    shifted = 8'h00;
    result  = 9'h000;
    case (sc)
      8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
      8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
      8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
      8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
      8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
      8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
      8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
      8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
      8'h35: lower = "y";  8'h1A: lower = "z";
      default: ;
    endcase
    case (sc)
      8'h45: begin plain = "0"; shifted = ")"; end
      8'h16: begin plain = "1"; shifted = "!"; end
      8'h1E: begin plain = "2"; shifted = "@"; end
      8'h26: begin plain = "3"; shifted = "#"; end
      8'h25: begin plain = "4"; shifted = "$"; end
      8'h2E: begin plain = "5"; shifted = "%"; end
      8'h36: begin plain = "6"; shifted = "^"; end
      8'h3D: begin plain = "7"; shifted = "&"; end
      8'h3E: begin plain = "8"; shifted = "*"; end
      8'h46: begin plain = "9"; shifted = "("; end
      default: ;
    endcase
    if (lower != 8'h00) begin
      result = {1'b1, (shift ^ caps) ? (lower - 8'h20) : lower};
    end else if (plain != 8'h00) begin
      result = {1'b1, shift ? shifted : plain};
    end else begin
      case (sc)
        8'h29:   result = {1'b1, ASCII_SP};
        8'h5A:   result = {1'b1, ASCII_CR};
        8'h66:   result = {1'b1, ASCII_BS};
        default: result = 9'h000;
      endcase
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_key_to_uart_fifo.sv
// Small first-word-fall-through byte queue. Pointers carry one extra wrap bit
// so full and empty fall out of a plain subtraction.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [AW:0] w_count;
  logic        w_wr_en;
  logic        w_rd_en;

  assign w_count = r_wr - r_rd;
  assign o_full  = (w_count == (AW+1)'(DEPTH));
  assign o_empty = (w_count == '0);
  assign w_rd_en = i_pop && !o_empty;
  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_head  = r_mem[r_rd[AW-1:0]];

  // Pointer update; reset discards queued contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_rd_en) r_rd <= r_rd + 1'b1;
    end
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ps2_key_to_uart.sv
// PS/2 Set-2 scancode stream to paced ASCII bytes for a UART without busy.
//
// state   | meaning
// IDLE    | no prefix pending; next byte is a make code
// EXT     | E0 seen; next byte is an extended make (ignored)
// BRK     | F0 seen; next byte is a key release
// EXT_BRK | E0 F0 seen; next byte is an extended release (ignored)
module ps2_key_to_uart #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 110000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       new_code,
  output logic [7:0] send_data,
  output logic       en_send,
  output logic       shift_on,
  output logic       caps_on,
  output logic       overflow
);
  import ps2_kbd_pkg::*;

  localparam int GW = ($clog2(GAP_CYCLES) < 1) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  kbd_state_t    r_state;
  kbd_state_t    w_state_next;
  logic          w_is_make;
  logic          w_is_break;
  logic          r_lshift;
  logic          r_rshift;
  logic          r_caps;
  logic [8:0]    w_lut;
  logic          r_push;
  logic [7:0]    r_push_data;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_head;
  logic          w_pop;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_send_data;
  logic          r_overflow;

  // Prefix state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Prefix decode: a fresh E0/F0 always restarts the sequence.
  always_comb begin
    w_state_next = r_state;
    w_is_make    = 1'b0;
    w_is_break   = 1'b0;
    if (new_code) begin
      if (scancode == SC_EXT) begin
        w_state_next = ST_EXT;
      end else if (scancode == SC_BRK) begin
        w_state_next = (r_state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else begin
        w_state_next = ST_IDLE;
        case (r_state)
          ST_IDLE: w_is_make  = 1'b1;
          ST_BRK:  w_is_break = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign shift_on = r_lshift | r_rshift;
  assign caps_on  = r_caps;

  // Modifier tracking; each shift key owns its own flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
    end else if (w_is_make) begin
      if (scancode == SC_LSHIFT) r_lshift <= 1'b1;
      if (scancode == SC_RSHIFT) r_rshift <= 1'b1;
      if (scancode == SC_CAPS)   r_caps   <= ~r_caps;
    end else if (w_is_break) begin
      if (scancode == SC_LSHIFT) r_lshift <= 1'b0;
      if (scancode == SC_RSHIFT) r_rshift <= 1'b0;
    end
  end

  // Lookup uses the modifier state before this byte takes effect.
  assign w_lut = sc_to_ascii(scancode, shift_on, r_caps);

  // Register the translated byte; it enters the queue next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
    end else begin
      r_push      <= w_is_make && w_lut[8];
      r_push_data <= w_lut[7:0];
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // The send strobe is the pop itself, so send_data shows the head during
  // the pulse and the captured copy afterwards.
  assign w_pop     = !reset && !w_fifo_empty && (r_gap == '0);
  assign en_send   = w_pop;
  assign send_data = w_pop ? w_head : r_send_data;
  assign overflow  = r_overflow;

  // Pacing counter and held output byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap       <= '0;
      r_send_data <= 8'h00;
    end else if (w_pop) begin
      r_gap       <= GAP_LOAD;
      r_send_data <= w_head;
    end else if (r_gap != '0) begin
      r_gap       <= r_gap - GW'(1);
    end
  end

  // Sticky drop flag: push while full and nothing leaving.
  always_ff @(posedge clk) begin
    if (reset)                                  r_overflow <= 1'b0;
    else if (r_push && w_fifo_full && !w_pop)   r_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_ps2_key_to_uart.sv
// Directed scancode sequences; expected bytes and their pulse cycles are
// queued at stimulus time and checked by an independent en_send monitor.
module tb_ps2_key_to_uart;
  localparam int GAP = 20;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scancode = 8'h00;
  logic       new_code = 1'b0;
  logic [7:0] send_data;
  logic       en_send;
  logic       shift_on;
  logic       caps_on;
  logic       overflow;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_strobe = 0;
  int   last_exp = -1000;

  ps2_key_to_uart #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .scancode  (scancode),
    .new_code  (new_code),
    .send_data (send_data),
    .en_send   (en_send),
    .shift_on  (shift_on),
    .caps_on   (caps_on),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic put(input logic [7:0] sc);
    @(negedge clk);
    scancode    = sc;
    new_code    = 1'b1;
    last_strobe = cyc;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    new_code = 1'b0;
    scancode = 8'h00;
    repeat (n - 1) @(negedge clk);
  endtask

  // Byte from the latest strobe: 2 cycles later, but never closer than GAP
  // to the previously expected pulse.
  task automatic expect_byte(input logic [7:0] d);
    int e;
    e = last_strobe + 2;
    if (e < last_exp + GAP) e = last_exp + GAP;
    last_exp = e;
    exp_q.push_back('{data: d, cyc: e});
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && en_send) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_en_send: actual=%02h required=no pulse (cycle %0d)", send_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("send_data", {24'h0, send_data}, {24'h0, e.data});
        chk("send_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_send_data", {24'h0, send_data}, 0);
    chk("rst_en_send", {31'h0, en_send}, 0);
    chk("rst_shift", {31'h0, shift_on}, 0);
    chk("rst_caps", {31'h0, caps_on}, 0);
    chk("rst_overflow", {31'h0, overflow}, 0);
    reset = 1'b0;
    idle(3);

    // Make then break of 'a'
    put(8'h1C); expect_byte(8'h61);
    put(8'hF0); put(8'h1C);
    idle(40);

    // Left shift held over a letter and a digit, then released
    put(8'h12);
    put(8'h1C); expect_byte(8'h41);
    put(8'h16); expect_byte(8'h21);
    idle(1);
    chk("shift_held", {31'h0, shift_on}, 1);
    put(8'hF0); put(8'h12);
    idle(1);
    chk("shift_released", {31'h0, shift_on}, 0);
    put(8'h1C); expect_byte(8'h61);
    idle(80);

    // Right shift
    put(8'h59);
    put(8'h1A); expect_byte(8'h5A);
    put(8'h1E); expect_byte(8'h40);
    put(8'hF0); put(8'h59);
    idle(1);
    chk("rshift_released", {31'h0, shift_on}, 0);
    idle(80);

    // CapsLock, shift cancelling caps, digits unaffected by caps
    put(8'h58);
    idle(1);
    chk("caps_on", {31'h0, caps_on}, 1);
    put(8'h1C); expect_byte(8'h41);
    put(8'h12);
    put(8'h1C); expect_byte(8'h61);
    put(8'hF0); put(8'h12);
    put(8'h45); expect_byte(8'h30);
    put(8'hF0); put(8'h58);
    idle(1);
    chk("caps_break_noop", {31'h0, caps_on}, 1);
    put(8'h58);
    idle(1);
    chk("caps_off", {31'h0, caps_on}, 0);
    idle(80);

    // Extended sequences produce nothing; then space, enter, backspace, unmapped
    put(8'hE0); put(8'h75);
    put(8'hE0); put(8'hF0); put(8'h75);
    put(8'hE0); put(8'h12);
    idle(1);
    chk("ext_shift_ignored", {31'h0, shift_on}, 0);
    put(8'h29); expect_byte(8'h20);
    put(8'h5A); expect_byte(8'h0D);
    put(8'h66); expect_byte(8'h08);
    put(8'h76);
    idle(80);
    chk("send_data_held", {24'h0, send_data}, 32'h08);

    // Burst of six makes into a four-entry queue
    chk("overflow_clear", {31'h0, overflow}, 0);
    put(8'h1C); expect_byte(8'h61);
    put(8'h32); expect_byte(8'h62);
    put(8'h21); expect_byte(8'h63);
    put(8'h23); expect_byte(8'h64);
    put(8'h24); expect_byte(8'h65);
    put(8'h2B);
    idle(2);
    chk("overflow_set", {31'h0, overflow}, 1);
    idle(120);

    // Reset with bytes queued, mid-gap, modifiers set and F0 pending
    put(8'h12); put(8'h58);
    put(8'h1C); expect_byte(8'h61);
    put(8'h32); put(8'h21); put(8'h23);
    put(8'hF0);
    idle(6);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    last_exp = -1000;
    @(negedge clk);
    chk("mid_rst_send_data", {24'h0, send_data}, 0);
    chk("mid_rst_en_send", {31'h0, en_send}, 0);
    chk("mid_rst_shift", {31'h0, shift_on}, 0);
    chk("mid_rst_caps", {31'h0, caps_on}, 0);
    chk("mid_rst_overflow", {31'h0, overflow}, 0);
    reset = 1'b0;
    idle(60);
    put(8'h1C); expect_byte(8'h61);
    idle(40);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
